logic_gates_bist: RTL and testbench
===================================

# logic_gates_bist

Self-checking stimulus/response stage wrapped around the two-input gate bank (`logic_gates`). It drives the gate bank's `x`/`y` inputs through all four input combinations, waits a programmable settle time, then compares the seven gate outputs against golden values. It accumulates mismatch statistics and reports pass/fail with a done pulse, so the gate bank can be checked in-system without a simulator monitor.

## Interface
- `SETTLE_CYCLES`, default 1: cycles between driving a vector and sampling outputs; legal range 1..15.
- `LOOPS`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `ERR_W`, default 8: width of the mismatch counter.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: run request; sampled only in IDLE.
- `x  out  1`: stimulus to gate bank, registered.
- `y  out  1`: stimulus to gate bank, registered.
- `a`..`g`  in  1 each: gate outputs, with golden values as follows.
  - a = x&y
  - b = x|y
  - c = ~x
  - d = ~(x&y)
  - e = ~(x|y)
  - f = x^y
  - g = ~(x^y)
- `busy  out  1`: high in SETTLE/CHECK.
- `done  out  1`: one-cycle pulse at end of run.
- `pass  out  1`: last run had zero mismatches.
- `err_cnt  out  ERR_W`: count of failing vectors (not failing bits), saturating.
- `fail_vec  out  7`: sticky per-output mismatch flags, bit0=a … bit6=g.
- `first_fail_xy  out  2`: {x,y} of first failing vector in the run.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, on `start`=1:
  - clear `err_cnt`, `fail_vec`, `first_fail_xy`, `pass`
  - load vector index 0 ({x,y}=00), loop count 0, settle counter = SETTLE_CYCLES
  - go to SETTLE
- SETTLE: decrement the settle counter each cycle. Go to CHECK when the counter reaches 1 (SETTLE lasts exactly SETTLE_CYCLES cycles).
- CHECK (one cycle): compare a..g against golden values for the current {x,y}.
  - Any mismatch:
    - OR mismatch bits into `fail_vec`
    - `err_cnt`+1, saturating at 2^ERR_W−1
    - if this is the first failure of the run, capture {x,y} into `first_fail_xy`
  - Last vector: index 3 and loop count = LOOPS−1. Go to DONE.
  - Otherwise: advance to the next vector (order 00,01,10,11, then wrap to 00 with loop count +1), reload the settle counter, go to SETTLE.
- DONE (one cycle): `done`=1; `pass` = (`err_cnt`==0 including this run's final compare); go to IDLE.
- Vector encoding: x = idx[1], y = idx[0].
- `start` is ignored in SETTLE, CHECK and DONE. No queuing.
- Results (`pass`, `err_cnt`, `fail_vec`, `first_fail_xy`) hold after DONE until the next accepted `start`.
- Reset (any time, including mid-run):
  - FSM to IDLE
  - all outputs 0: x, y, busy, done, pass, err_cnt, fail_vec, first_fail_xy

## Timing
- Per vector: SETTLE_CYCLES + 1 cycles.
- Run length: 4·LOOPS·(SETTLE_CYCLES+1) cycles after the edge that accepts `start`. `done` is high in the following cycle.
- Example, defaults: `start` accepted at edge 0; x,y = 00/01/10/11 during cycles 1–2/3–4/5–6/7–8; `done` high in cycle 9.
- x,y change only on the edge that enters SETTLE, so they are stable throughout SETTLE and CHECK.
- Outputs a..g are sampled combinationally in CHECK. The gate bank is purely combinational, so SETTLE_CYCLES=1 is sufficient.
- `busy` falls on the edge entering DONE. `done` and `busy` are never high together.

## Configuration
- `LOGIC_GATES_BIST_STOP_ON_FAIL_EN`
  - Defined: the first CHECK with any mismatch goes directly to DONE after recording it. `err_cnt` ≤ 1 and `pass`=0.
  - Undefined: all 4·LOOPS vectors always run regardless of failures.

## Test plan
- Correct gate bank, defaults, pulse `start` → x,y = 00,01,10,11 with 2 cycles each; `done` in cycle 9; `pass`=1; `err_cnt`=0; `fail_vec`=0.
- `a` forced to 0 → only vector 11 fails: `err_cnt`=1, `fail_vec`=7'b0000001, `first_fail_xy`=2'b11, `pass`=0.
- `f` inverted, LOOPS=3 → every vector fails: `err_cnt`=12, `fail_vec`=7'b0100000, `first_fail_xy`=2'b00.
- ERR_W=2, `f` inverted, LOOPS=2 → `err_cnt` saturates at 3. Then start again with a correct bank → `err_cnt`=0, `pass`=1.
- `start` pulsed during cycle 4 of a run → ignored, run length unchanged. `rst_n` low in cycle 5 → all outputs 0 immediately, FSM to IDLE, next `start` runs normally.
- Macro defined, `f` inverted, defaults → `done` in cycle 3, `err_cnt`=1, `first_fail_xy`=00. Macro undefined, same stimulus → `done` in cycle 9, `err_cnt`=4.

Source files
------------

// File: rtl/logic_gates_bist_if.sv
// rtl/logic_gates_bist_if.sv - control, status and gate-bank signals of the logic gate BIST
interface logic_gates_bist_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             x;
  logic             y;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             e;
  logic             f;
  logic             g;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [6:0]       fail_vec;
  logic [1:0]       first_fail_xy;

  modport master (
    output start, a, b, c, d, e, f, g,
    input  x, y, busy, done, pass, err_cnt, fail_vec, first_fail_xy
  );

  modport slave (
    input  start, a, b, c, d, e, f, g,
    output x, y, busy, done, pass, err_cnt, fail_vec, first_fail_xy
  );
endinterface

// File: rtl/logic_gates_bist.sv
// rtl/logic_gates_bist.sv - stimulus/response self-test of the two-input gate bank
// Optional: LOGIC_GATES_BIST_STOP_ON_FAIL_EN ends the run at the first failing vector.
module logic_gates_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  logic_gates_bist_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [7:0]       loop_cnt;
  logic [3:0]       settle_cnt;
  logic             x_q;
  logic             y_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [6:0]       fvec_q;
  logic [1:0]       ffxy_q;

  logic [6:0]       golden;
  logic [6:0]       observed;
  logic [6:0]       mism;
  logic [ERR_W-1:0] err_next;
  logic             last_vec;

  // Bit order matches fail_vec: bit0=a ... bit6=g
  assign golden   = {~(x_q ^ y_q), x_q ^ y_q, ~(x_q | y_q), ~(x_q & y_q),
                     ~x_q, x_q | y_q, x_q & y_q};
  assign observed = {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  assign mism     = observed ^ golden;

`ifdef LOGIC_GATES_BIST_STOP_ON_FAIL_EN
  assign last_vec = ((idx == 2'd3) && (loop_cnt == 8'(LOOPS - 1))) || (|mism);
`else
  assign last_vec = (idx == 2'd3) && (loop_cnt == 8'(LOOPS - 1));
`endif

  always_comb begin
    err_next = err_q;
    if ((|mism) && (err_q != {ERR_W{1'b1}}))
      err_next = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      loop_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
      x_q        <= 1'b0;
      y_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fvec_q     <= 7'd0;
      ffxy_q     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            err_q      <= '0;
            fvec_q     <= 7'd0;
            ffxy_q     <= 2'd0;
            pass_q     <= 1'b0;
            idx        <= 2'd0;
            loop_cnt   <= 8'd0;
            settle_cnt <= 4'(SETTLE_CYCLES);
            x_q        <= 1'b0;
            y_q        <= 1'b0;
            busy_q     <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd1)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (|mism) begin
            fvec_q <= fvec_q | mism;
            err_q  <= err_next;
            // Saturation never returns to zero, so zero means no earlier failure
            if (err_q == '0)
              ffxy_q <= {x_q, y_q};
          end
          if (last_vec) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == '0);
            state  <= DONE;
          end else begin
            idx        <= idx + 2'd1;
            {x_q, y_q} <= idx + 2'd1;
            if (idx == 2'd3)
              loop_cnt <= loop_cnt + 8'd1;
            settle_cnt <= 4'(SETTLE_CYCLES);
            state      <= SETTLE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.fail_vec      = fvec_q;
  assign bus.first_fail_xy = ffxy_q;
endmodule

// File: tb/tb_logic_gates_bist.sv
// tb/tb_logic_gates_bist.sv - directed-vector bench for logic_gates_bist
module tb_logic_gates_bist;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_gates_bist_if #(.ERR_W(8)) if0 ();
  logic_gates_bist_if #(.ERR_W(8)) if1 ();
  logic_gates_bist_if #(.ERR_W(2)) if2 ();

  logic_gates_bist #(.SETTLE_CYCLES(1), .LOOPS(1), .ERR_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  logic_gates_bist #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  logic_gates_bist #(.SETTLE_CYCLES(1), .LOOPS(2), .ERR_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Fault modes: 0 = healthy bank, 1 = a stuck at 0, 2 = f inverted
  int         fault [3];
  logic [2:0] start_s;
  logic [1:0] xy_s [3];
  logic       busy_s [3];
  logic       done_s [3];

  function automatic logic [6:0] bank(input logic x, input logic y, input int flt);
    logic [6:0] r;
    r = {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
    if (flt == 1) r[0] = 1'b0;
    if (flt == 2) r[5] = ~r[5];
    return r;
  endfunction

  assign if0.start = start_s[0];
  assign if1.start = start_s[1];
  assign if2.start = start_s[2];
  assign {if0.g, if0.f, if0.e, if0.d, if0.c, if0.b, if0.a} = bank(if0.x, if0.y, fault[0]);
  assign {if1.g, if1.f, if1.e, if1.d, if1.c, if1.b, if1.a} = bank(if1.x, if1.y, fault[1]);
  assign {if2.g, if2.f, if2.e, if2.d, if2.c, if2.b, if2.a} = bank(if2.x, if2.y, fault[2]);
  assign xy_s[0] = {if0.x, if0.y};
  assign xy_s[1] = {if1.x, if1.y};
  assign xy_s[2] = {if2.x, if2.y};
  assign busy_s[0] = if0.busy;
  assign busy_s[1] = if1.busy;
  assign busy_s[2] = if2.busy;
  assign done_s[0] = if0.done;
  assign done_s[1] = if1.done;
  assign done_s[2] = if2.done;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Cycle 1 is the cycle after the edge that accepts start.
  task automatic run(input int sel, input int poke, output int done_cyc,
                     output logic [15:0] trace, output int overlap, output int extra);
    done_cyc = -1;
    trace    = '0;
    overlap  = 0;
    extra    = 0;
    @(negedge clk);
    start_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_s[sel] = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c <= 8) trace = {trace[13:0], xy_s[sel]};
      if (busy_s[sel] && done_s[sel]) overlap++;
      if (done_s[sel]) begin
        done_cyc = c;
        break;
      end
      start_s[sel] = (c == poke);
      @(posedge clk);
      #1;
    end
    start_s[sel] = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_s[sel]) extra++;
    end
  endtask

  int          dc;
  logic [15:0] tr;
  int          ov;
  int          ex;

  initial begin
    rst_n   = 1'b0;
    start_s = 3'b000;
    fault[0] = 0;
    fault[1] = 0;
    fault[2] = 0;
    repeat (2) @(negedge clk);
    check("rst_xy",    {30'd0, if0.x, if0.y}, 32'd0);
    check("rst_busy",  {31'd0, if0.busy}, 32'd0);
    check("rst_done",  {31'd0, if0.done}, 32'd0);
    check("rst_pass",  {31'd0, if0.pass}, 32'd0);
    check("rst_err",   {24'd0, if0.err_cnt}, 32'd0);
    check("rst_fvec",  {25'd0, if0.fail_vec}, 32'd0);
    check("rst_ffxy",  {30'd0, if0.first_fail_xy}, 32'd0);
    rst_n = 1'b1;

    // Healthy bank, defaults
    run(0, 0, dc, tr, ov, ex);
    check("ok_done_cyc", dc, 32'd9);
    check("ok_trace",    {16'd0, tr}, 32'h05AF);
    check("ok_overlap",  ov, 32'd0);
    check("ok_extra",    ex, 32'd0);
    check("ok_pass",     {31'd0, if0.pass}, 32'd1);
    check("ok_err",      {24'd0, if0.err_cnt}, 32'd0);
    check("ok_fvec",     {25'd0, if0.fail_vec}, 32'd0);
    check("ok_busy",     {31'd0, if0.busy}, 32'd0);

    // a stuck at 0: only vector 11 fails
    fault[0] = 1;
    run(0, 0, dc, tr, ov, ex);
    check("a0_done_cyc", dc, 32'd9);
    check("a0_err",      {24'd0, if0.err_cnt}, 32'd1);
    check("a0_fvec",     {25'd0, if0.fail_vec}, 32'h01);
    check("a0_ffxy",     {30'd0, if0.first_fail_xy}, 32'd3);
    check("a0_pass",     {31'd0, if0.pass}, 32'd0);

    // f inverted, defaults
    fault[0] = 2;
    run(0, 0, dc, tr, ov, ex);
`ifdef LOGIC_GATES_BIST_STOP_ON_FAIL_EN
    check("f_done_cyc", dc, 32'd3);
    check("f_err",      {24'd0, if0.err_cnt}, 32'd1);
`else
    check("f_done_cyc", dc, 32'd9);
    check("f_err",      {24'd0, if0.err_cnt}, 32'd4);
`endif
    check("f_ffxy",     {30'd0, if0.first_fail_xy}, 32'd0);
    check("f_fvec",     {25'd0, if0.fail_vec}, 32'h20);
    check("f_pass",     {31'd0, if0.pass}, 32'd0);

    // f inverted, LOOPS=3, SETTLE_CYCLES=2
    fault[1] = 2;
    run(1, 0, dc, tr, ov, ex);
`ifdef LOGIC_GATES_BIST_STOP_ON_FAIL_EN
    check("l3_done_cyc", dc, 32'd4);
    check("l3_err",      {24'd0, if1.err_cnt}, 32'd1);
`else
    check("l3_done_cyc", dc, 32'd37);
    check("l3_err",      {24'd0, if1.err_cnt}, 32'd12);
`endif
    check("l3_fvec",     {25'd0, if1.fail_vec}, 32'h20);
    check("l3_ffxy",     {30'd0, if1.first_fail_xy}, 32'd0);
    check("l3_overlap",  ov, 32'd0);

    // ERR_W=2 saturation, then a clean rerun clears results
    fault[2] = 2;
    run(2, 0, dc, tr, ov, ex);
`ifdef LOGIC_GATES_BIST_STOP_ON_FAIL_EN
    check("sat_err",  {30'd0, if2.err_cnt}, 32'd1);
`else
    check("sat_err",  {30'd0, if2.err_cnt}, 32'd3);
`endif
    check("sat_pass", {31'd0, if2.pass}, 32'd0);
    fault[2] = 0;
    run(2, 0, dc, tr, ov, ex);
    check("clr_done_cyc", dc, 32'd17);
    check("clr_err",      {30'd0, if2.err_cnt}, 32'd0);
    check("clr_pass",     {31'd0, if2.pass}, 32'd1);
    check("clr_fvec",     {25'd0, if2.fail_vec}, 32'd0);

    // start pulsed mid-run is neither honoured nor queued
    fault[0] = 0;
    run(0, 4, dc, tr, ov, ex);
    check("poke_done_cyc", dc, 32'd9);
    check("poke_extra",    ex, 32'd0);
    check("poke_trace",    {16'd0, tr}, 32'h05AF);

    // Asynchronous reset in cycle 5 of a failing run
    fault[0] = 2;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_xy",   {30'd0, if0.x, if0.y}, 32'd0);
    check("mid_rst_busy", {31'd0, if0.busy}, 32'd0);
    check("mid_rst_err",  {24'd0, if0.err_cnt}, 32'd0);
    check("mid_rst_fvec", {25'd0, if0.fail_vec}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fault[0] = 0;
    run(0, 0, dc, tr, ov, ex);
    check("post_rst_done_cyc", dc, 32'd9);
    check("post_rst_pass",     {31'd0, if0.pass}, 32'd1);
    check("post_rst_trace",    {16'd0, tr}, 32'h05AF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
